// File: rtl/rtc_bus_engine.sv
// ---------------------------------------------------------------------------
// rtc_bus_engine
//
// Bus-cycle generator for the RTC chip's multiplexed address/data port.
// Runs one read or write transaction per accepted start through four timed
// phases: ADDR, GAP, DATA and REC. Each phase lasts its T_* cycles. The
// AD tristate buffer is at top level; this block only supplies ad_out and
// ad_oe.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   start        request strobe, sampled only while idle
//   rw           0 = write, 1 = read (latched with start)
//   addr         RTC register address (latched with start)
//   wdata        write data (latched with start)
//   ad_in        AD bus value from the pad (read path)
//   ad_out       value driven onto the AD bus
//   ad_oe        1 = drive the AD bus
//   cs_n         chip select, active low
//   ale_n        address strobe, active low
//   rd_n, wr_n   read / write strobes, active low
//   rdata        last byte read
//   busy         transaction in progress
//   done         one-cycle completion pulse
// ---------------------------------------------------------------------------
module rtc_bus_engine #(
  parameter int T_ADDR = 10,
  parameter int T_GAP  = 10,
  parameter int T_DATA = 20,
  parameter int T_REC  = 10,
  parameter int CW     = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ale_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] REC  = 3'd4;

  // Down-counter reload values: a phase loaded with T-1 leaves on the edge
  // where the counter reads zero, so it lasts exactly T cycles.
  localparam logic [CW-1:0] LD_ADDR = CW'(T_ADDR - 1);
  localparam logic [CW-1:0] LD_GAP  = CW'(T_GAP - 1);
  localparam logic [CW-1:0] LD_DATA = CW'(T_DATA - 1);
  localparam logic [CW-1:0] LD_REC  = CW'(T_REC - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          rw_q;
  logic [7:0]    addr_q;
  logic [7:0]    wdata_q;

  wire phase_end = (cnt == '0);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      cs_n   <= 1'b1;
      ale_n  <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= 8'h00;
      rdata  <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= ADDR;
            cnt    <= LD_ADDR;
            busy   <= 1'b1;
            cs_n   <= 1'b0;
            ale_n  <= 1'b0;
            ad_oe  <= 1'b1;
            ad_out <= addr;
          end
        end
        ADDR: begin
          if (phase_end) begin
            state <= GAP;
            cnt   <= LD_GAP;
            ale_n <= 1'b1;
            // A read releases the bus here so the chip can turn it around.
            ad_oe <= ~rw_q;
            if (!rw_q) ad_out <= wdata_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (phase_end) begin
            state <= DATA;
            cnt   <= LD_DATA;
            if (rw_q) begin
              rd_n  <= 1'b0;
              ad_oe <= 1'b0;
            end else begin
              wr_n   <= 1'b0;
              ad_oe  <= 1'b1;
              ad_out <= wdata_q;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (phase_end) begin
            state <= REC;
            cnt   <= LD_REC;
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            cs_n  <= 1'b1;
            ad_oe <= 1'b0;
            // Captures the bus value present during the last strobe cycle.
            if (rw_q) rdata <= ad_in;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REC: begin
          if (phase_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the latched request is deliberately not reset; it is always
  // loaded in IDLE before any phase reads it, and loading only while idle
  // keeps a start seen during busy from corrupting the request in flight.
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      rw_q    <= rw;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

endmodule

// File: tb/tb_rtc_bus_engine.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_engine
//
// Two engines share one set of inputs: one with the default phase widths and
// one with every phase one cycle long. A transaction-level model per engine
// predicts every output from the number of cycles elapsed since the start
// edge, and is compared with the engine outputs once per cycle.
// ---------------------------------------------------------------------------
module tb_rtc_bus_engine;

  logic       clock;
  logic       reset;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] ad_in;

  logic [7:0] ad_out [2];
  logic       ad_oe  [2];
  logic       cs_n   [2];
  logic       ale_n  [2];
  logic       rd_n   [2];
  logic       wr_n   [2];
  logic [7:0] rdata  [2];
  logic       busy   [2];
  logic       done   [2];

  int checks = 0;
  int errors = 0;

  rtc_bus_engine u_dut_def (
    .clock(clock), .reset(reset), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out[0]), .ad_oe(ad_oe[0]),
    .cs_n(cs_n[0]), .ale_n(ale_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]),
    .rdata(rdata[0]), .busy(busy[0]), .done(done[0])
  );

  rtc_bus_engine #(
    .T_ADDR(1), .T_GAP(1), .T_DATA(1), .T_REC(1), .CW(1)
  ) u_dut_min (
    .clock(clock), .reset(reset), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out[1]), .ad_oe(ad_oe[1]),
    .cs_n(cs_n[1]), .ale_n(ale_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]),
    .rdata(rdata[1]), .busy(busy[1]), .done(done[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Phase widths of each engine.
  int ta [2] = '{10, 1};
  int tg [2] = '{10, 1};
  int td [2] = '{20, 1};
  int tr [2] = '{10, 1};

  // Model state: cycles elapsed since the start edge plus the latched request.
  bit         m_act   [2];
  int         m_k     [2];
  logic       m_rw    [2];
  logic [7:0] m_addr  [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_rdata [2];
  logic [7:0] m_adout [2];
  bit         m_done  [2];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i]   = 1'b0;
        m_k[i]     = 0;
        m_done[i]  = 1'b0;
        m_rdata[i] = 8'h00;
        m_adout[i] = 8'h00;
      end else if (m_act[i]) begin
        m_done[i] = 1'b0;
        m_k[i]++;
        if (m_k[i] == ta[i] + tg[i] + td[i] && m_rw[i]) m_rdata[i] = ad_in;
        if (m_k[i] == ta[i] + tg[i] + td[i] + tr[i]) begin
          m_act[i]  = 1'b0;
          m_done[i] = 1'b1;
        end
      end else begin
        m_done[i] = 1'b0;
        if (start) begin
          m_act[i]   = 1'b1;
          m_k[i]     = 0;
          m_rw[i]    = rw;
          m_addr[i]  = addr;
          m_wdata[i] = wdata;
        end
      end
      if (m_act[i])
        m_adout[i] = (m_k[i] < ta[i] || m_rw[i]) ? m_addr[i] : m_wdata[i];
    end
  endtask

  function automatic logic [22:0] expected(input int i);
    int  k;
    bit  a;
    bit  strobe;
    k      = m_k[i];
    a      = m_act[i];
    strobe = a && k >= ta[i] + tg[i] && k < ta[i] + tg[i] + td[i];
    return {a,
            m_done[i],
            ~(a && k < ta[i] + tg[i] + td[i]),
            ~(a && k < ta[i]),
            ~(strobe && m_rw[i]),
            ~(strobe && !m_rw[i]),
            a && (k < ta[i] || (!m_rw[i] && k < ta[i] + tg[i] + td[i])),
            m_adout[i],
            m_rdata[i]};
  endfunction

  function automatic logic [22:0] observed(input int i);
    return {busy[i], done[i], cs_n[i], ale_n[i], rd_n[i], wr_n[i], ad_oe[i],
            ad_out[i], rdata[i]};
  endfunction

  int done_seen;

  // One clock: predict the edge, let it happen, compare on the falling edge.
  task automatic tick();
    model_edge();
    @(negedge clock);
    check("eng_def", 32'(observed(0)), 32'(expected(0)));
    check("eng_min", 32'(observed(1)), 32'(expected(1)));
    if (done[0] === 1'b1) done_seen++;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rw    = 1'b0;
    addr  = 8'h00;
    wdata = 8'h00;
    ad_in = 8'h00;
    ticks(3);
    reset = 1'b0;
    ticks(2);

    // Write 0x45 to 0x21; request inputs churn afterwards and must be ignored.
    start = 1'b1; rw = 1'b0; addr = 8'h21; wdata = 8'h45;
    tick();
    start = 1'b0;
    for (int j = 0; j < 55; j++) begin
      rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      ad_in = 8'($urandom);
      tick();
    end

    // Read from 0x22 with 0x37 on the bus.
    start = 1'b1; rw = 1'b1; addr = 8'h22; ad_in = 8'h37;
    tick();
    start = 1'b0;
    ticks(55);
    check("read_rdata", 32'(rdata[0]), 32'h37);

    // start held high: back-to-back transactions, one done every 51 cycles.
    done_seen = 0;
    start = 1'b1; rw = 1'b0;
    for (int j = 0; j < 153; j++) begin
      addr = 8'($urandom); wdata = 8'($urandom); ad_in = 8'($urandom);
      tick();
    end
    check("held_start_dones", 32'(done_seen), 32'd3);
    start = 1'b0;
    ticks(60);

    // Stray start pulses mid-transaction with a new address.
    done_seen = 0;
    start = 1'b1; rw = 1'b1; addr = 8'h5a; ad_in = 8'h3c;
    tick();
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      start = (c == 4 || c == 29);
      addr  = (c >= 4) ? 8'h99 : 8'h5a;
      ad_in = 8'($urandom);
      tick();
    end
    start = 1'b0;
    check("stray_start_dones", 32'(done_seen), 32'd1);

    // Reset in the middle of a write strobe, then a full clean transaction.
    start = 1'b1; rw = 1'b0; addr = 8'h10; wdata = 8'hc3;
    tick();
    start = 1'b0;
    ticks(25);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_busy", 32'(busy[0]), 32'd0);
    start = 1'b1; rw = 1'b1; addr = 8'h33;
    tick();
    start = 1'b0;
    for (int j = 0; j < 55; j++) begin
      ad_in = 8'($urandom);
      tick();
    end

    // Randomized traffic with occasional resets.
    for (int j = 0; j < 3000; j++) begin
      start = ($urandom_range(0, 7) == 0);
      rw    = 1'($urandom);
      addr  = 8'($urandom);
      wdata = 8'($urandom);
      ad_in = 8'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    ticks(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_engine.md
Name: rtc_bus_engine

Overview:
- Bus-cycle generator for the RTC chip's multiplexed address/data port.
- Accepts a single read or write request from the clock control FSM, or from its init, data-write and data-read sub-blocks, through a start/busy/done handshake.
- Drives CS_n, A/D (ale_n), RD_n and WR_n with programmable phase widths, and returns read data captured from the bus.
- Sits between the control/mux layer and the top-level bidirectional AD pad; the tristate buffer lives at top level.

Parameters:
- T_ADDR, 10: cycles of the address phase (cs_n=0, ale_n=0, address on bus).
- T_GAP, 10: cycles between ale_n rising and the data strobe (address hold / bus turnaround).
- T_DATA, 20: cycles the rd_n or wr_n strobe is held low.
- T_REC, 10: recovery cycles with all strobes high before done.
- CW, 6: phase counter width. Every T_* must satisfy 1 <= T_* <= 2^CW.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request strobe, sampled only when idle
- rw  in  1  0=write, 1=read; latched with start
- addr  in  8  RTC register address; latched with start
- wdata  in  8  write data; latched with start
- ad_in  in  8  AD bus value from pad (read path)
- ad_out  out  8  value driven onto AD bus
- ad_oe  out  1  1=drive AD bus
- cs_n  out  1  chip select, active low
- ale_n  out  1  A/D address strobe, active low
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- rdata  out  8  last read byte
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered.
- Reset values: cs_n=1, ale_n=1, rd_n=1, wr_n=1, ad_oe=0, ad_out=0x00, rdata=0x00, busy=0, done=0, state=IDLE.
- States: IDLE, ADDR, GAP, DATA, REC.
  - On entering each phase, a down-counter loads T_x-1; the phase exits on the edge where the counter reads 0.
  - Each phase therefore lasts exactly T_x cycles.
- IDLE, start=1 sampled at edge E0:
  - Latch rw, addr, wdata.
  - Enter ADDR with busy=1, cs_n=0, ale_n=0, ad_oe=1, ad_out=addr.
  - done=0, unless a done pulse was due on this same edge (see back-to-back rule).
- ADDR -> GAP:
  - ale_n=1, cs_n stays 0.
  - Write: ad_oe=1, ad_out=wdata.
  - Read: ad_oe=0 (bus turnaround).
- GAP -> DATA:
  - Write: wr_n=0, ad_out=wdata, ad_oe=1.
  - Read: rd_n=0, ad_oe=0.
- DATA -> REC:
  - rd_n=1, wr_n=1, cs_n=1, ad_oe=0.
  - Read: rdata <= ad_in, sampled on this exiting edge, i.e. the value present during the last DATA cycle.
  - Write: rdata unchanged.
- REC -> IDLE: busy=0 and done=1 for exactly one cycle.
- Timing with defaults, E0 = start edge, cycles counted after E0:
  - ADDR cycles 0-9, GAP 10-19, DATA 20-39, REC 40-49.
  - done high in cycle 50.
  - Total latency start-edge to done = T_ADDR+T_GAP+T_DATA+T_REC.
- Back-to-back:
  - start high in the done cycle is accepted at the next edge.
  - start is ignored while busy=1; it is neither queued nor allowed to corrupt the latched request.
- addr/wdata/rw changes during a transaction have no effect.
- Reset mid-transaction:
  - At the next edge, all strobes go high, ad_oe=0, busy=0, no done pulse, rdata=0x00.
- cs_n is never low while busy=0.
- rd_n and wr_n are never low simultaneously.
- ad_oe is never 1 while rd_n=0.

Test Plan:
- Write, rw=0, addr=0x21, wdata=0x45, defaults -> ale_n low cycles 0-9 with ad_out=0x21; wr_n low cycles 20-39 with ad_out=0x45 and ad_oe=1; cs_n low cycles 0-39; done single pulse at cycle 50; rdata unchanged.
- Read, rw=1, addr=0x22, ad_in=0x37 during cycles 20-39 -> ad_oe=0 from cycle 10; rd_n low cycles 20-39; rdata=0x37 from cycle 40; done at cycle 50.
- start held high continuously for 3 transactions -> second ADDR begins in cycle 51; exactly 3 done pulses 51 cycles apart; no overlap of cs_n cycles.
- start pulses at cycles 5 and 30 during a busy transaction, with addr changed to 0x99 -> ignored; bus shows original addr; one done only.
- reset asserted at cycle 25 of a write -> cycle 26: wr_n=1, cs_n=1, ad_oe=0, busy=0; no done; next start runs a full normal cycle.
- Parameters T_ADDR=1, T_GAP=1, T_DATA=1, T_REC=1, read -> phases each 1 cycle; done at cycle 4; rdata = ad_in value of cycle 2.
